// File: rtl/mux_sel_sequencer_if.sv
// Handshake and mux-drive bundle between an upstream word source and the
// select sequencer. The master side supplies words; the slave side is the
// sequencer that drives the 8:1 mux data and select inputs.
interface mux_sel_sequencer_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] d;
    logic [2:0] s;
    logic       sel_valid;
    logic       first;
    logic       last;
    logic       done;

    modport master (
        output in_valid, in_data,
        input  in_ready, d, s, sel_valid, first, last, done
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, d, s, sel_valid, first, last, done
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// Select sequencer for an 8:1 mux stage. A word accepted over valid/ready is
// held on the mux data bus while the select steps through all eight indices,
// each held HOLD_CYCLES cycles, so the mux output is the word serialized.
module mux_sel_sequencer #(
    parameter int HOLD_CYCLES = 1,
    parameter bit MSB_FIRST   = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, SCAN} state_t;

    // Scan starts at bit 0 or bit 7; stepping by 7 is a 3-bit decrement.
    localparam logic [2:0] START     = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [2:0] STEP      = MSB_FIRST ? 3'd7 : 3'd1;
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [7:0] d_q;
    logic [2:0] s_q;
    logic [7:0] hold_cnt_q;
    logic [2:0] slot_cnt_q;
    logic       sel_valid_q;
    logic       done_q;

    // Frame FSM: accept in IDLE, walk the select in SCAN, pulse done on exit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            d_q         <= 8'h00;
            s_q         <= START;
            hold_cnt_q  <= 8'd0;
            slot_cnt_q  <= 3'd0;
            sel_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        d_q         <= bus.in_data;
                        s_q         <= START;
                        hold_cnt_q  <= 8'd0;
                        slot_cnt_q  <= 3'd0;
                        sel_valid_q <= 1'b1;
                        state_q     <= SCAN;
                    end
                end
                SCAN: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        hold_cnt_q <= 8'd0;
                        if (slot_cnt_q != 3'd7) begin
                            s_q        <= s_q + STEP;
                            slot_cnt_q <= slot_cnt_q + 3'd1;
                        end else begin
                            // Final slot finished: back to IDLE so the next
                            // word can be taken in the same cycle done is high.
                            s_q         <= START;
                            slot_cnt_q  <= 3'd0;
                            sel_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready is held low during reset and otherwise follows the IDLE state.
    assign bus.in_ready  = rst_n && (state_q == IDLE);
    assign bus.d         = d_q;
    assign bus.s         = s_q;
    assign bus.sel_valid = sel_valid_q;
    assign bus.done      = done_q;
    assign bus.first     = (state_q == SCAN) && (slot_cnt_q == 3'd0);
    assign bus.last      = (state_q == SCAN) && (slot_cnt_q == 3'd7);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Bench for mux_sel_sequencer: two instances (HOLD=1 LSB-first and HOLD=3
// MSB-first). Stimulus pushes per-cycle expected outputs into a queue per
// instance; a negedge monitor pops and compares whenever sel_valid or done.
module tb_mux_sel_sequencer;

    typedef struct {
        int         cyc;
        bit         is_done;
        logic [2:0] s;
        logic       y;
        logic       first;
        logic       last;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;
    exp_t q0[$];
    exp_t q1[$];

    mux_sel_sequencer_if b0 ();
    mux_sel_sequencer_if b1 ();

    mux_sel_sequencer #(.HOLD_CYCLES(1), .MSB_FIRST(1'b0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b0)
    );

    mux_sel_sequencer #(.HOLD_CYCLES(3), .MSB_FIRST(1'b1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time-stamp expected outputs.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Expected frame: ncyc valid cycles from accept cycle a, then optional done.
    task automatic push_frame(input int inst, input logic [7:0] w, input int a,
                              input int hold, input bit msb, input int ncyc,
                              input bit with_done);
        exp_t e;
        int   slot;
        for (int k = 0; k < ncyc; k++) begin
            slot      = k / hold;
            e.cyc     = a + k;
            e.is_done = 1'b0;
            e.s       = 3'(msb ? 7 - slot : slot);
            e.y       = w[e.s];
            e.first   = (slot == 0);
            e.last    = (slot == 7);
            e.d       = w;
            if (inst == 0) q0.push_back(e); else q1.push_back(e);
        end
        if (with_done) begin
            e.cyc     = a + 8 * hold;
            e.is_done = 1'b1;
            e.s       = 3'(msb ? 7 : 0);
            e.y       = 1'b0;
            e.first   = 1'b0;
            e.last    = 1'b0;
            e.d       = w;
            if (inst == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    task automatic mon(input int inst, input logic sv, input logic dn,
                       input logic [2:0] s, input logic [7:0] d, input logic f,
                       input logic l, input logic rdy);
        exp_t  e;
        logic  y;
        string t;
        if (sv !== 1'b1 && dn !== 1'b1) return;
        t = $sformatf("u%0d", inst);
        if ((inst == 0 && q0.size() == 0) || (inst == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL %s unexpected output at cyc %0d: sel_valid=%b done=%b, expected none",
                     t, cyc, sv, dn);
            return;
        end
        if (inst == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({t, " cycle"}, 32'(cyc), 32'(e.cyc));
        chk({t, " done"}, 32'(dn), 32'(e.is_done));
        if (e.is_done) begin
            chk({t, " ready_on_done"}, 32'(rdy), 32'd1);
            chk({t, " sel_valid_on_done"}, 32'(sv), 32'd0);
            chk({t, " s_on_done"}, 32'(s), 32'(e.s));
        end else begin
            y = d[s];
            chk({t, " s"}, 32'(s), 32'(e.s));
            chk({t, " y"}, 32'(y), 32'(e.y));
            chk({t, " d"}, 32'(d), 32'(e.d));
            chk({t, " first"}, 32'(f), 32'(e.first));
            chk({t, " last"}, 32'(l), 32'(e.last));
            chk({t, " ready_busy"}, 32'(rdy), 32'd0);
        end
    endtask

    // Scoreboard monitor: sample both instances away from the active edge.
    always @(negedge clk) begin
        mon(0, b0.sel_valid, b0.done, b0.s, b0.d, b0.first, b0.last, b0.in_ready);
        mon(1, b1.sel_valid, b1.done, b1.s, b1.d, b1.first, b1.last, b1.in_ready);
    end

    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    // Offer a word at a negedge; returns the cycle index right after the edge.
    task automatic send(input int inst, input logic [7:0] w, input bit keep, output int a);
        @(negedge clk);
        if (inst == 0) begin
            b0.in_valid = 1'b1;
            b0.in_data  = w;
            chk("u0 ready_before_accept", 32'(b0.in_ready), 32'd1);
        end else begin
            b1.in_valid = 1'b1;
            b1.in_data  = w;
            chk("u1 ready_before_accept", 32'(b1.in_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        a = cyc;
        if (!keep) begin
            if (inst == 0) b0.in_valid = 1'b0; else b1.in_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int a1;
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        b0.in_valid = 1'b0;
        b0.in_data  = 8'h00;
        b1.in_valid = 1'b0;
        b1.in_data  = 8'h00;

        // Reset then idle.
        repeat (2) @(posedge clk);
        #1;
        chk("rst ready_low", 32'(b0.in_ready), 32'd0);
        chk("rst sel_valid", 32'(b0.sel_valid), 32'd0);
        chk("rst s_u0", 32'(b0.s), 32'd0);
        chk("rst d_u0", 32'(b0.d), 32'h00);
        chk("rst done", 32'(b0.done), 32'd0);
        chk("rst first", 32'(b0.first), 32'd0);
        chk("rst last", 32'(b0.last), 32'd0);
        chk("rst s_u1", 32'(b1.s), 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle ready_u0", 32'(b0.in_ready), 32'd1);
        chk("idle ready_u1", 32'(b1.in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("idle sel_valid", 32'(b0.sel_valid), 32'd0);
        chk("idle s", 32'(b0.s), 32'd0);
        chk("idle d", 32'(b0.d), 32'h00);

        // Basic scan, HOLD=1, LSB first.
        send(0, 8'b1010_1010, 1'b0, a);
        push_frame(0, 8'b1010_1010, a, 1, 1'b0, 8, 1'b1);
        wait_neg(a + 12);

        // HOLD=3, MSB first.
        send(1, 8'hC3, 1'b0, a);
        push_frame(1, 8'hC3, a, 3, 1'b1, 24, 1'b1);
        wait_neg(a + 30);

        // Back-to-back with in_valid held and in_data changing mid-frame.
        send(0, 8'hF0, 1'b1, a1);
        push_frame(0, 8'hF0, a1, 1, 1'b0, 8, 1'b1);
        wait_neg(a1 + 3);
        b0.in_data = 8'h55;
        wait_neg(a1 + 8);
        b0.in_data = 8'h0F;
        chk("b2b ready_on_done", 32'(b0.in_ready), 32'd1);
        push_frame(0, 8'h0F, a1 + 9, 1, 1'b0, 8, 1'b1);
        @(posedge clk);
        #1;
        b0.in_valid = 1'b0;
        wait_neg(a1 + 22);

        // Reset while s=4.
        send(0, 8'h3C, 1'b0, a);
        push_frame(0, 8'h3C, a, 1, 1'b0, 5, 1'b0);
        wait_neg(a + 4);
        chk("midrst s_before", 32'(b0.s), 32'd4);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst sel_valid", 32'(b0.sel_valid), 32'd0);
        chk("midrst s", 32'(b0.s), 32'd0);
        chk("midrst d", 32'(b0.d), 32'h00);
        chk("midrst done", 32'(b0.done), 32'd0);
        chk("midrst first", 32'(b0.first), 32'd0);
        chk("midrst last", 32'(b0.last), 32'd0);
        chk("midrst ready", 32'(b0.in_ready), 32'd0);
        chk("midrst s_u1", 32'(b1.s), 32'd7);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("postrst ready", 32'(b0.in_ready), 32'd1);

        // Handshake gap: in_valid pulse during SCAN is ignored.
        send(0, 8'h96, 1'b0, a);
        push_frame(0, 8'h96, a, 1, 1'b0, 8, 1'b1);
        wait_neg(a + 3);
        b0.in_valid = 1'b1;
        b0.in_data  = 8'h11;
        chk("gap ready_busy", 32'(b0.in_ready), 32'd0);
        @(negedge clk);
        b0.in_valid = 1'b0;
        wait_neg(a + 20);
        chk("gap d_held", 32'(b0.d), 32'h96);

        chk("q0 drained", 32'(q0.size()), 32'd0);
        chk("q1 drained", 32'(q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
